// File: rtl/dram_traffic_gen.sv
// dram_traffic_gen: writes an address-derived pattern over a rank/bank/row/col region, reads it back READ_PASSES times and checks returns in order.
// Ports: clk/power_on_rst (sync active-high), start pulse, ba_cmd_pm per-bank ready, read_data/read_data_valid returns;
// command/write_data/valid issue port, busy/done/timeout status, err_count/first_err_addr error capture, total_cycles/rd_cycles statistics.
module dram_traffic_gen #(
  parameter int          NUM_BANKS   = 1,
  parameter int          NUM_ROWS    = 128,
  parameter int          NUM_COLS    = 880,
  parameter int          RANK        = 0,
  parameter int          READ_PASSES = 4,
  parameter int          INTERLEAVE  = 0,
  parameter logic [31:0] SEED        = 32'hA5C3_0F69,
  parameter int          TIMEOUT     = 4096,
  parameter int          DATA_W      = 128
) (
  input  logic              clk,
  input  logic              power_on_rst,
  input  logic              start,
  input  logic [3:0]        ba_cmd_pm,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic [35:0]       command,
  output logic [DATA_W-1:0] write_data,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [31:0]       first_err_addr,
  output logic [31:0]       total_cycles,
  output logic [31:0]       rd_cycles
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  typedef struct packed {logic [2:0] b; logic [12:0] r; logic [9:0] c;} addr_t;
  localparam logic [2:0]  BL    = 3'(NUM_BANKS - 1);
  localparam logic [12:0] RL    = 13'(NUM_ROWS - 1);
  localparam logic [9:0]  CL    = 10'(NUM_COLS - 8);
  localparam logic [3:0]  PL    = 4'(READ_PASSES - 1);
  localparam logic [31:0] TOTAL = 32'(NUM_BANKS * NUM_ROWS * (NUM_COLS / 8) * READ_PASSES);
  localparam logic [31:0] TL    = 32'(TIMEOUT - 1);
  localparam logic [2:0]  RK    = 3'(RANK);
  function automatic logic last(input addr_t a);
    return a.b == BL && a.r == RL && a.c == CL;
  endfunction
  // One step of the sweep; both issue and checker iterators use it so read order matches issue order.
  function automatic addr_t nxt(input addr_t a);
    addr_t n;
    logic lb, lr, lc;
    lb = a.b == BL;
    lr = a.r == RL;
    lc = a.c == CL;
    if (INTERLEAVE == 0) begin
      n.c = lc ? 10'd0 : a.c + 10'd8;
      n.r = !lc ? a.r : lr ? 13'd0 : a.r + 13'd1;
      n.b = !(lc && lr) ? a.b : lb ? 3'd0 : a.b + 3'd1;
    end else begin
      n.b = lb ? 3'd0 : a.b + 3'd1;
      n.c = !lb ? a.c : lc ? 10'd0 : a.c + 10'd8;
      n.r = !(lb && lc) ? a.r : lr ? 13'd0 : a.r + 13'd1;
    end
    return n;
  endfunction
  function automatic logic [DATA_W-1:0] pat(input addr_t a);
    logic [31:0] k;
    k = {6'd0, a};
    return {k ^ {SEED[7:0], SEED[31:8]}, k ^ {SEED[15:0], SEED[31:16]}, k ^ {SEED[23:0], SEED[31:24]}, k ^ SEED};
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
  state_t            state_q, state_d;
  addr_t             ia_q, ia_d, ea_q, ea_d;
  logic [3:0]        pass_q, pass_d;
  logic [35:0]       cmd_q, cmd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              vld_q, vld_d, to_q, to_d, rds_q, rds_d;
  logic [15:0]       err_q, err_d;
  logic [31:0]       fea_q, fea_d, tot_q, tot_d, rdc_q, rdc_d;
  logic [31:0]       out_q, out_d, ret_q, ret_d, idle_q, idle_d;
  logic              act, issue, rd_iss, ret;
  assign busy = state_q == WRITE || state_q == READ || state_q == DRAIN;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    ia_d = ia_q;
    ea_d = ea_q;
    pass_d = pass_q;
    cmd_d = '0;
    wd_d = '0;
    vld_d = 1'b0;
    to_d = to_q;
    err_d = err_q;
    fea_d = fea_q;
    tot_d = busy ? sat(tot_q) : tot_q;
    out_d = out_q;
    ret_d = ret_q;
    idle_d = idle_q;
    act = state_q == READ || state_q == DRAIN;
    issue = (state_q == WRITE || state_q == READ) && ba_cmd_pm[ia_q.b[1:0]];
    rd_iss = issue && state_q == READ;
    ret = act && read_data_valid;
    rds_d = rds_q | rd_iss;
    rdc_d = act && rds_q ? sat(rdc_q) : rdc_q;
    if (issue) begin
      vld_d = 1'b1;
      cmd_d = {RK, 1'b0, state_q == READ, 1'b0, ia_q.r, 4'b0100, ia_q.c, ia_q.b};
      wd_d = state_q == WRITE ? pat(ia_q) : '0;
      ia_d = nxt(ia_q);
      if (last(ia_q)) begin
        state_d = state_q == WRITE ? READ : pass_q == PL ? DRAIN : READ;
        pass_d = state_q == READ ? pass_q + 4'd1 : pass_q;
      end
    end
    out_d = out_q + 32'(rd_iss) - 32'(ret);
    if (ret) begin
      ea_d = nxt(ea_q);
      ret_d = ret_q + 32'd1;
      if (read_data != pat(ea_q)) begin
        err_d = &err_q ? err_q : err_q + 16'd1;
        fea_d = err_q == '0 ? {6'd0, ea_q} : fea_q;
      end
    end
    if (act) idle_d = ret ? '0 : out_q != '0 ? idle_q + 32'd1 : idle_q;
    if (state_q == DRAIN && out_d == '0 && ret_d == TOTAL) state_d = DONE;
    if (act && !ret && out_q != '0 && idle_q == TL) begin
      to_d = 1'b1;
      state_d = DONE;
    end
    // start in IDLE launches a run; start in DONE returns to IDLE; both clear all run state
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d = state_q == IDLE ? WRITE : IDLE;
      ia_d = '0;
      ea_d = '0;
      pass_d = '0;
      to_d = 1'b0;
      err_d = '0;
      fea_d = '0;
      tot_d = '0;
      rdc_d = '0;
      out_d = '0;
      ret_d = '0;
      idle_d = '0;
      rds_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      state_q <= IDLE;
      ia_q <= '0;
      ea_q <= '0;
      pass_q <= '0;
      cmd_q <= '0;
      wd_q <= '0;
      vld_q <= 1'b0;
      to_q <= 1'b0;
      rds_q <= 1'b0;
      err_q <= '0;
      fea_q <= '0;
      tot_q <= '0;
      rdc_q <= '0;
      out_q <= '0;
      ret_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      ia_q <= ia_d;
      ea_q <= ea_d;
      pass_q <= pass_d;
      cmd_q <= cmd_d;
      wd_q <= wd_d;
      vld_q <= vld_d;
      to_q <= to_d;
      rds_q <= rds_d;
      err_q <= err_d;
      fea_q <= fea_d;
      tot_q <= tot_d;
      rdc_q <= rdc_d;
      out_q <= out_d;
      ret_q <= ret_d;
      idle_q <= idle_d;
    end
  end
  assign command = cmd_q;
  assign write_data = wd_q;
  assign valid = vld_q;
  assign timeout = to_q;
  assign err_count = err_q;
  assign first_err_addr = fea_q;
  assign total_cycles = tot_q;
  assign rd_cycles = rdc_q;
endmodule

// File: tb/tb_dram_traffic_gen.sv
// tb_dram_traffic_gen: scoreboard bench for dram_traffic_gen on a small interleaved 4-bank region with a memory-backed return model.
module tb_dram_traffic_gen;
  localparam int NB = 4, NR = 2, NC = 16, RP = 2, TO = 64;
  localparam int NREAD = NB * NR * (NC / 8) * RP;
  localparam logic [31:0] S = 32'hA5C3_0F69;
  logic clk = 1'b0, power_on_rst = 1'b1, start = 1'b0, read_data_valid = 1'b0;
  logic [3:0] ba_cmd_pm = 4'hF;
  logic [127:0] read_data = '0;
  logic [35:0] command;
  logic [127:0] write_data;
  logic valid, busy, done, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, total_cycles, rd_cycles;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int n_wr = 0, n_rd = 0, n_ret = 0, last_ret = 0, at = 0;
  bit toggle = 0, corrupt = 0, drop = 0;
  logic [35:0] exp_cmd[$];
  logic [127:0] exp_wd[$];
  logic [35:0] seen[$];
  logic [127:0] wd0;
  int due[$];
  logic [25:0] raddr[$];
  logic [127:0] mem[logic [25:0]];

  dram_traffic_gen #(.NUM_BANKS(NB), .NUM_ROWS(NR), .NUM_COLS(NC), .RANK(0), .READ_PASSES(RP),
                     .INTERLEAVE(1), .SEED(S), .TIMEOUT(TO), .DATA_W(128)) dut (
    .clk(clk), .power_on_rst(power_on_rst), .start(start), .ba_cmd_pm(ba_cmd_pm),
    .read_data(read_data), .read_data_valid(read_data_valid), .command(command),
    .write_data(write_data), .valid(valid), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .total_cycles(total_cycles),
    .rd_cycles(rd_cycles));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [25:0] a);
    logic [31:0] key;
    logic [127:0] v;
    key = {6'd0, a};
    for (int k = 0; k < 4; k++) v[32*k +: 32] = key ^ ((S << (8 * k)) | (S >> (32 - 8 * k)));
    return v;
  endfunction

  // Expected issue stream for one run: write pass then RP read passes, bank innermost.
  task automatic expect_run();
    exp_cmd.delete();
    exp_wd.delete();
    seen.delete();
    for (int p = 0; p <= RP; p++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c += 8)
          for (int b = 0; b < NB; b++) begin
            exp_cmd.push_back({3'd0, p == 0 ? 2'b00 : 2'b01, 1'b0, 13'(r), 4'b0100, 10'(c), 3'(b)});
            exp_wd.push_back(p == 0 ? pat({3'(b), 13'(r), 10'(c)}) : 128'd0);
          end
  endtask

  // Monitor + controller model: checks each command, stores writes, returns reads 10 cycles later.
  always @(negedge clk) begin : mon
    logic [25:0] a;
    if (valid) begin
      a = {command[2:0], command[29:17], command[12:3]};
      seen.push_back(command);
      if (seen.size() == 1) wd0 = write_data;
      if (toggle) chk("ready_before_valid", 128'(ba_cmd_pm[command[1:0]]), 128'd1);
      if (exp_cmd.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_cmd: got %0h want none", command);
      end else begin
        chk("cmd", 128'(command), 128'(exp_cmd.pop_front()));
        chk("wdata", write_data, exp_wd.pop_front());
      end
      if (command[31]) begin
        n_rd++;
        due.push_back(cyc + 10);
        raddr.push_back(a);
      end else begin
        n_wr++;
        mem[a] = write_data;
      end
    end
    read_data_valid = 1'b0;
    read_data = '0;
    if (due.size() > 0 && due[0] == cyc) begin
      a = raddr.pop_front();
      void'(due.pop_front());
      if (!(drop && n_ret == NREAD - 1)) begin
        read_data_valid = 1'b1;
        read_data = mem[a] ^ ((corrupt && n_ret == 2) ? 128'h20 : 128'h0);
        last_ret = cyc;
      end
      n_ret++;
    end
    if (toggle) ba_cmd_pm = ~ba_cmd_pm;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && !done; i++) tick();
    at = cyc;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_done: done=0 after 2000 cycles, want 1");
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 128'({command, valid, busy, done, timeout, err_count}), 128'd0);
    chk({nm, "_wd"}, write_data, 128'd0);
    chk({nm, "_stats"}, 128'({first_err_addr, total_cycles, rd_cycles}), 128'd0);
  endtask

  task automatic run(input bit tg, input bit cr, input bit dr);
    toggle = tg;
    corrupt = cr;
    drop = dr;
    ba_cmd_pm = 4'hF;
    n_wr = 0;
    n_rd = 0;
    n_ret = 0;
    mem.delete();
    due.delete();
    raddr.delete();
    expect_run();
    pulse_start();
    wait_done();
    toggle = 1'b0;
    ba_cmd_pm = 4'hF;
  endtask

  task automatic to_idle(input string nm);
    pulse_start();
    chk({nm, "_idle"}, 128'({busy, done, timeout, err_count}), 128'd0);
    chk({nm, "_idle_stats"}, 128'({first_err_addr, total_cycles, rd_cycles}), 128'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_zero("in_reset");
    power_on_rst = 1'b0;
    tick();
    chk_zero("after_reset");

    run(0, 1, 0);
    chk("a_done_to", 128'({done, timeout}), 128'b10);
    chk("a_left", exp_cmd.size(), 0);
    chk("a_writes", n_wr, 16);
    chk("a_reads", n_rd, 32);
    chk("a_err", err_count, 1);
    chk("a_first_err", first_err_addr, 32'h0100_0000);
    chk("a_total", total_cycles, 59);
    chk("a_rd_cycles", rd_cycles, 42);
    chk("a_cmd0", seen[0], 36'h0_0000_8000);
    chk("a_cmd1", seen[1], 36'h0_0000_8001);
    chk("a_cmd4", seen[4], 36'h0_0000_8040);
    chk("a_cmd8", seen[8], 36'h0_0002_8000);
    chk("a_cmd16", seen[16], 36'h0_8000_8000);
    chk("a_cmd47", seen[47], 36'h0_8002_8043);
    chk("a_wd0", wd0, 128'h69A5C30F_0F69A5C3_C30F69A5_A5C30F69);
    to_idle("a");

    run(1, 0, 0);
    chk("b_done_to", 128'({done, timeout}), 128'b10);
    chk("b_left", exp_cmd.size(), 0);
    chk("b_counts", 128'({n_wr, n_rd}), 128'({32'd16, 32'd32}));
    chk("b_err", err_count, 0);
    chk("b_rd_cycles", rd_cycles, 73);
    chk("b_total_2x", 128'(total_cycles >= 106 && total_cycles <= 107), 1);
    to_idle("b");

    run(0, 0, 1);
    chk("c_done_to", 128'({done, timeout}), 128'b11);
    chk("c_err", err_count, 0);
    chk("c_reads", n_rd, 32);
    chk("c_to_delay", at - (last_ret + 1), TO);
    to_idle("c");

    ba_cmd_pm = 4'hF;
    n_rd = 0;
    expect_run();
    pulse_start();
    for (int i = 0; i < 500 && n_rd < 5; i++) tick();
    chk("d_in_read", 128'(n_rd >= 5), 1);
    power_on_rst = 1'b1;
    tick();
    chk_zero("d_reset");
    power_on_rst = 1'b0;
    tick();
    chk_zero("d_released");
    run(0, 0, 0);
    chk("d_done_to", 128'({done, timeout}), 128'b10);
    chk("d_left", exp_cmd.size(), 0);
    chk("d_err", err_count, 0);
    chk("d_total", total_cycles, 59);
    chk("d_cmd0", seen[0], 36'h0_0000_8000);
    chk("d_wd0", wd0, 128'h69A5C30F_0F69A5C3_C30F69A5_A5C30F69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_traffic_gen.md
Name: dram_traffic_gen

Overview:
Synthesizable, parametrised traffic generator and checker for the DRAM controller command port. It writes a deterministic address-derived data pattern over a configurable rank/bank/row/column region, then reads the region back for READ_PASSES passes. Returned data is checked in order against the regenerated pattern, without a shadow memory. It replaces the fixed single-bank, single-rank stimulus and adds bank interleaving, a timeout, error capture and cycle statistics.

Parameters:
NUM_BANKS, 1, banks swept, 1..4
NUM_ROWS, 128, rows swept per bank, starting at row 0
NUM_COLS, 880, columns swept per row; must be a multiple of 8; one burst covers 8 columns
RANK, 0, rank field value placed in every command
READ_PASSES, 4, full read-back passes after the write pass, 1..15
INTERLEAVE, 0, 0 = bank outermost (bank, row, col); 1 = bank innermost (row, col, bank)
SEED, 32'hA5C3_0F69, pattern seed
TIMEOUT, 4096, idle cycles allowed while reads are outstanding before abort
DATA_W, 128, data width; fixed at 4 lanes of 32 bits

Ports:
clk  in  1  system clock
power_on_rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
ba_cmd_pm  in  4  per-bank ready from controller; bit[bank] gates issue
read_data  in  DATA_W  read return data
read_data_valid  in  1  read return strobe; returns arrive in command order
command  out  36  {rank[35:33], rw[32:31], 0, row[29:17], 0, bl[15], 0, auto_pre[13], col[12:3], bank[2:0]}
write_data  out  DATA_W  write payload, aligned with its write command
valid  out  1  command and write_data valid this cycle
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
timeout  out  1  sticky abort flag
err_count  out  16  saturating mismatch count
first_err_addr  out  32  {bank, row, col} of the first mismatch, zero-extended
total_cycles  out  32  cycles spent busy
rd_cycles  out  32  cycles from the first read issue to the final read return

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, and all counters are cleared. A reset in any state aborts immediately; no command is issued in the cycle after reset.
- FSM states: IDLE -> WRITE on start -> READ after the last write issues -> DRAIN after the last read of the final pass issues -> DONE after the last return or on timeout -> IDLE on the next start. A start seen in DONE clears statistics and err_count, and clears the timeout flag.
- Address iterator: the column steps by 8; rw = 00 for write and 01 for read; bl = 1; auto_pre = 0. The iterator wraps to its first address between passes.
- Issue rule, evaluated each clk edge in WRITE or READ:
  - If ba_cmd_pm[cur_bank] = 1, then next cycle command = current address, valid = 1, and the iterator advances.
  - Otherwise valid = 0 and command = 0; the iterator holds.
  - valid never stays high without a corresponding advance, so every valid cycle is exactly one new command.
- Write data: write_data is registered together with its command and is 0 on read cycles and idle cycles.
  - Pattern: key = zero-extended {bank, row, col}; lane k (bits 32k+31:32k) = key XOR rotl(SEED, 8k).
- Checker:
  - Runs an independent expected-address iterator in read order (same ordering as issue, wrapping each pass).
  - On each read_data_valid it compares read_data with the pattern for that address and advances.
  - A mismatch increments err_count, saturating at 16'hFFFF.
  - The first mismatch latches first_err_addr; later mismatches do not change it.
  - Returns are counted from READ entry only. A read_data_valid in IDLE, WRITE or DONE is ignored.
- Outstanding count: +1 per read issue, -1 per return; a simultaneous issue and return leaves it unchanged.
- Timeout: an idle counter resets on any return and increments while outstanding > 0 with no return. On reaching TIMEOUT it sets timeout and moves to DONE; the remaining returns are ignored.
- DONE is entered when outstanding = 0 and returns = NUM_BANKS*NUM_ROWS*(NUM_COLS/8)*READ_PASSES.
- Statistics: total_cycles increments every cycle busy = 1. rd_cycles runs from the first read valid through the cycle of the last return. Both hold in DONE and saturate at all-ones.

Test Plan:
- Default parameters, ba_cmd_pm = 4'hF, and a model returning reads 10 cycles after issue -> 14080 writes, 56320 reads, err_count = 0, done = 1, timeout = 0; the first write is row 0, col 0 with lane0 = 32'hA5C3_0F69.
- INTERLEAVE = 1, NUM_BANKS = 4, NUM_ROWS = 2, NUM_COLS = 16 -> write order is bank 0,1,2,3 at (r0,c0), then (r0,c8), and so on; 16 writes total.
- Toggle ba_cmd_pm[0] every other cycle -> valid appears only in cycles following ready = 1, no address is skipped or repeated, and total_cycles is about 2x the command count.
- Corrupt bit 5 of the 3rd read return in pass 1 -> err_count = 1 and first_err_addr = {0, row 0, col 16}.
- Model drops the last return -> timeout = 1 and done = 1 exactly TIMEOUT cycles after the last return.
- Assert power_on_rst mid-READ, then start -> all outputs are 0 the next cycle, the rerun begins with the row 0, col 0 write, and err_count = 0.
